dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the CPU load/store stage (cpu_*) and a DMA/debug loader (dma_*).
- Uses fixed CPU priority with a starvation counter that forces a DMA grant.
- Blocks stores that fault on misalignment so they never reach memory.
- Returns a registered response, with read data and exception status, to the requester that won.
- Sits between the pipeline MEM stage / debug port and the dmem block.

---
 rtl/dmem_arbiter.sv | 87 ++++++++
 tb/tb_dmem_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the CPU MEM stage and a DMA/debug loader,
// CPU-first with a starvation override, returning a registered one-cycle response to the winner.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_rw,
    input  logic [2:0]  cpu_funct3,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_rsp_valid,
    output logic [31:0] cpu_rsp_rdata,
    output logic        cpu_rsp_exc,
    output logic [3:0]  cpu_rsp_exc_code,
    input  logic        dma_req_valid,
    output logic        dma_req_ready,
    input  logic        dma_rw,
    input  logic [2:0]  dma_funct3,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_rsp_valid,
    output logic [31:0] dma_rsp_rdata,
    output logic        dma_rsp_exc,
    output logic [3:0]  dma_rsp_exc_code,
    output logic        mem_rw,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_exception
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             gnt_cpu;
    logic             gnt_dma;
    logic             g_rw;
    logic [31:0]      load_data;
    logic [CNT_W-1:0] starve_cnt;
    logic             last_grant;

    // rst gates the grant so nothing is accepted or written while reset is asserted
    always_comb begin
        gnt_dma     = !rst && dma_req_valid && (!cpu_req_valid || starve_cnt == LIMIT);
        gnt_cpu     = !rst && cpu_req_valid && !gnt_dma;
        g_rw        = gnt_dma ? dma_rw : (gnt_cpu && cpu_rw);
        mem_rw      = g_rw && !mem_exception;
        mem_funct3  = gnt_dma ? dma_funct3 : gnt_cpu ? cpu_funct3 : 3'b000;
        mem_address = gnt_dma ? dma_addr   : gnt_cpu ? cpu_addr   : 32'h0;
        mem_wdata   = gnt_dma ? dma_wdata  : gnt_cpu ? cpu_wdata  : 32'h0;
        load_data   = (!g_rw && !mem_exception) ? mem_rdata : 32'h0;
    end

    assign cpu_req_ready = gnt_cpu;
    assign dma_req_ready = gnt_dma;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rsp_valid    <= 1'b0;
            cpu_rsp_rdata    <= 32'h0;
            cpu_rsp_exc      <= 1'b0;
            cpu_rsp_exc_code <= 4'h0;
            dma_rsp_valid    <= 1'b0;
            dma_rsp_rdata    <= 32'h0;
            dma_rsp_exc      <= 1'b0;
            dma_rsp_exc_code <= 4'h0;
            starve_cnt       <= '0;
            last_grant       <= 1'b0;
        end else begin
            cpu_rsp_valid    <= gnt_cpu;
            cpu_rsp_rdata    <= gnt_cpu ? load_data : 32'h0;
            cpu_rsp_exc      <= gnt_cpu && mem_exception;
            cpu_rsp_exc_code <= {3'b000, gnt_cpu && cpu_rw};
            dma_rsp_valid    <= gnt_dma;
            dma_rsp_rdata    <= gnt_dma ? load_data : 32'h0;
            dma_rsp_exc      <= gnt_dma && mem_exception;
            dma_rsp_exc_code <= {3'b000, gnt_dma && dma_rw};
            starve_cnt       <= (gnt_cpu && dma_req_valid) ?
                                ((starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1) : '0;
            if (gnt_cpu || gnt_dma)
                last_grant <= gnt_dma;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus against a byte-addressed dmem model; expected responses
// are queued per requester at acceptance and checked by a separate response monitor.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req_valid = 1'b0, cpu_req_ready, cpu_rw = 1'b0;
    logic [2:0]  cpu_funct3 = 3'b0;
    logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
    logic        cpu_rsp_valid, cpu_rsp_exc;
    logic [31:0] cpu_rsp_rdata;
    logic [3:0]  cpu_rsp_exc_code;
    logic        dma_req_valid = 1'b0, dma_req_ready, dma_rw = 1'b0;
    logic [2:0]  dma_funct3 = 3'b0;
    logic [31:0] dma_addr = 32'h0, dma_wdata = 32'h0;
    logic        dma_rsp_valid, dma_rsp_exc;
    logic [31:0] dma_rsp_rdata;
    logic [3:0]  dma_rsp_exc_code;
    logic        mem_rw, mem_exception;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_address, mem_wdata, mem_rdata;

    dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_rw(cpu_rw),
        .cpu_funct3(cpu_funct3), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
        .cpu_rsp_exc(cpu_rsp_exc), .cpu_rsp_exc_code(cpu_rsp_exc_code),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_rw(dma_rw),
        .dma_funct3(dma_funct3), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rsp_valid(dma_rsp_valid), .dma_rsp_rdata(dma_rsp_rdata),
        .dma_rsp_exc(dma_rsp_exc), .dma_rsp_exc_code(dma_rsp_exc_code),
        .mem_rw(mem_rw), .mem_funct3(mem_funct3), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_exception(mem_exception)
    );

    always #5 clk = ~clk;

    // dmem model: combinational read and misalign flag, write on the rising edge
    logic [7:0]  mem [0:255];
    logic [7:0]  ma;
    logic [31:0] mw;
    initial for (int i = 0; i < 256; i++) mem[i] = 8'h0;
    always_comb begin
        ma = mem_address[7:0];
        mw = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
        mem_exception = ((mem_funct3 == 3'b001 || mem_funct3 == 3'b101) && ma[0]) ||
                        (mem_funct3 == 3'b010 && ma[1:0] != 2'b00);
        case (mem_funct3)
            3'b000:  mem_rdata = {{24{mw[7]}}, mw[7:0]};
            3'b001:  mem_rdata = {{16{mw[15]}}, mw[15:0]};
            3'b010:  mem_rdata = mw;
            3'b100:  mem_rdata = {24'h0, mw[7:0]};
            3'b101:  mem_rdata = {16'h0, mw[15:0]};
            default: mem_rdata = 32'h0;
        endcase
    end
    always @(posedge clk) begin
        if (mem_rw) begin
            if (mem_funct3 == 3'b000 || mem_funct3 == 3'b001 || mem_funct3 == 3'b010)
                mem[mem_address[7:0]] = mem_wdata[7:0];
            if (mem_funct3 == 3'b001 || mem_funct3 == 3'b010)
                mem[mem_address[7:0] + 8'd1] = mem_wdata[15:8];
            if (mem_funct3 == 3'b010) begin
                mem[mem_address[7:0] + 8'd2] = mem_wdata[23:16];
                mem[mem_address[7:0] + 8'd3] = mem_wdata[31:24];
            end
        end
    end

    typedef struct packed {
        logic [31:0] rd;
        logic        exc;
        logic [3:0]  code;
        int          stamp;
    } exp_t;
    exp_t cpu_q[$];
    exp_t dma_q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit side, input logic [31:0] rd, input logic exc, input logic rw);
        exp_t e;
        e = '{rd: rd, exc: exc, code: {3'b000, rw}, stamp: cyc};
        if (side) dma_q.push_back(e);
        else cpu_q.push_back(e);
    endtask

    task automatic check_rsp(input bit side, input logic [31:0] rd, input logic exc, input logic [3:0] code);
        exp_t e;
        if (side ? dma_q.size() == 0 : cpu_q.size() == 0) begin
            chk(side ? "dma_unexpected_rsp" : "cpu_unexpected_rsp", 32'h1, 32'h0);
        end else begin
            e = side ? dma_q.pop_front() : cpu_q.pop_front();
            chk(side ? "dma_rdata" : "cpu_rdata", rd, e.rd);
            chk(side ? "dma_exc" : "cpu_exc", {31'h0, exc}, {31'h0, e.exc});
            chk(side ? "dma_code" : "cpu_code", {28'h0, code}, {28'h0, e.code});
            chk(side ? "dma_latency" : "cpu_latency", cyc, e.stamp + 1);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_rsp_valid) check_rsp(1'b0, cpu_rsp_rdata, cpu_rsp_exc, cpu_rsp_exc_code);
            if (dma_rsp_valid) check_rsp(1'b1, dma_rsp_rdata, dma_rsp_exc, dma_rsp_exc_code);
        end
    end

    task automatic drive(input bit side, input logic v, input logic rw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (side) begin
            dma_req_valid = v; dma_rw = rw; dma_funct3 = f3; dma_addr = a; dma_wdata = wd;
        end else begin
            cpu_req_valid = v; cpu_rw = rw; cpu_funct3 = f3; cpu_addr = a; cpu_wdata = wd;
        end
    endtask

    task automatic issue(input bit side, input logic rw, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_exc);
        @(negedge clk);
        drive(side, 1'b1, rw, f3, a, wd);
        #1;
        for (int n = 0; !(side ? dma_req_ready : cpu_req_ready); n++) begin
            if (n == 20) begin
                chk("ready_timeout", 32'h0, 32'h1);
                drive(side, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
                return;
            end
            @(negedge clk);
            #1;
        end
        chk("mem_rw", {31'h0, mem_rw}, {31'h0, rw && !exp_exc});
        push(side, exp_rd, exp_exc, rw);
        @(posedge clk);
        #1;
        drive(side, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    endtask

    initial begin
        cpu_req_valid = 1'b1;
        #12;
        chk("rst_cpu_ready", {31'h0, cpu_req_ready}, 32'h0);
        chk("rst_cpu_rsp_valid", {31'h0, cpu_rsp_valid}, 32'h0);
        chk("rst_starve_cnt", {28'h0, dut.starve_cnt}, 32'h0);
        chk("rst_mem_rw", {31'h0, mem_rw}, 32'h0);
        cpu_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        issue(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        issue(1, 1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 0);

        // both requesters held valid: CPU x4 then forced DMA, twice over
        @(negedge clk);
        drive(0, 1, 0, 3'b010, 32'h10, 32'h0);
        drive(1, 1, 0, 3'b010, 32'h40, 32'h0);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("cnt_cpu_ready", {31'h0, cpu_req_ready}, {31'h0, (i % 5) != 4});
            chk("cnt_dma_ready", {31'h0, dma_req_ready}, {31'h0, (i % 5) == 4});
            chk("starve_cnt", {28'h0, dut.starve_cnt}, i % 5);
            if ((i % 5) == 4) push(1, 32'hCAFEF00D, 0, 0);
            else push(0, 32'hDEADBEEF, 0, 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 3'b0, 32'h0, 32'h0);
        drive(1, 0, 0, 3'b0, 32'h0, 32'h0);

        issue(0, 1, 3'b010, 32'h13, 32'h11223344, 32'h0, 1);
        issue(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        issue(1, 0, 3'b001, 32'h21, 32'h0, 32'h0, 1);
        issue(1, 1, 3'b000, 32'h22, 32'h80, 32'h0, 0);
        issue(0, 0, 3'b000, 32'h22, 32'h0, 32'hFFFFFF80, 0);
        issue(0, 0, 3'b100, 32'h22, 32'h0, 32'h00000080, 0);
        issue(0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 0);

        // reset lands between edges while a CPU store is being presented
        @(negedge clk);
        drive(0, 1, 0, 3'b010, 32'h10, 32'h0);
        drive(1, 1, 0, 3'b010, 32'h40, 32'h0);
        #1;
        push(0, 32'hDEADBEEF, 0, 0);
        @(negedge clk);
        drive(0, 1, 1, 3'b010, 32'h30, 32'h55);
        #1;
        chk("pre_rst_cnt", {28'h0, dut.starve_cnt}, 32'h1);
        chk("pre_rst_mem_rw", {31'h0, mem_rw}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cpu_ready", {31'h0, cpu_req_ready}, 32'h0);
        chk("arst_dma_ready", {31'h0, dma_req_ready}, 32'h0);
        chk("arst_mem_rw", {31'h0, mem_rw}, 32'h0);
        chk("arst_mem_addr", mem_address, 32'h0);
        chk("arst_cpu_rsp_valid", {31'h0, cpu_rsp_valid}, 32'h0);
        chk("arst_starve_cnt", {28'h0, dut.starve_cnt}, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 3'b0, 32'h0, 32'h0);
        drive(1, 0, 0, 3'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cnt", {28'h0, dut.starve_cnt}, 32'h0);
        issue(0, 0, 3'b010, 32'h30, 32'h0, 32'h0, 0);

        repeat (3) @(negedge clk);
        chk("cpu_q_drained", cpu_q.size(), 32'h0);
        chk("dma_q_drained", dma_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
